// File: rtl/banner_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// banner_pkg: shared geometry, ROM/pixel widths and fetch FSM states
// Rev 1.0
// ------------------------------------------------------------------
package banner_pkg;
  localparam int W       = 168;
  localparam int H       = 12;
  localparam int V_TOTAL = 525;
  localparam int ADDR_W  = 11;
  localparam int PIX_W   = 8;
  localparam logic [PIX_W-1:0] KEY = 8'h00;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;
endpackage
`default_nettype wire

// File: rtl/line_buffer_pp.sv
`default_nettype none
// ------------------------------------------------------------------
// line_buffer_pp: two-bank line RAM, one write port, one async read
// Rev 1.0
// ------------------------------------------------------------------
module line_buffer_pp
  import banner_pkg::*;
#(
  parameter int DEPTH = W
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     wbank,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [PIX_W-1:0]         wdata,
  input  logic                     rbank,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [PIX_W-1:0]         rdata
);
  logic [PIX_W-1:0] mem [2][DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wbank][waddr] <= wdata;
  end

  assign rdata = mem[rbank][raddr];
endmodule
`default_nettype wire

// File: rtl/press_line_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// press_line_fetch: per-line banner row prefetch, display, blink, key
// Rev 1.0
// ------------------------------------------------------------------
module press_line_fetch #(
  parameter int         W            = banner_pkg::W,
  parameter int         H            = banner_pkg::H,
  parameter int         POS_X        = 236,
  parameter int         POS_Y        = 400,
  parameter int         V_TOTAL      = banner_pkg::V_TOTAL,
  parameter int         BLINK_FRAMES = 30,
  parameter logic [7:0] KEY          = banner_pkg::KEY
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_line_start,
  input  logic [9:0]                    i_line_y,
  input  logic                          i_frame_start,
  input  logic                          i_blink_en,
  input  logic [9:0]                    i_x,
  output logic [banner_pkg::ADDR_W-1:0] o_rom_addr,
  input  logic [7:0]                    i_rom_data,
  output logic [7:0]                    o_pix,
  output logic                          o_pix_valid,
  output logic                          o_busy,
  output logic                          o_overrun
);
  import banner_pkg::*;

  localparam int CW = $clog2(W);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [CW-1:0] LAST_COL = CW'(W - 1);

  fetch_state_e      state, state_nx;
  logic [BW-1:0]     blink_cnt, blink_cnt_nx;
  logic              visible, visible_nx;
  logic              front, back;
  logic [1:0]        bank_valid;
  logic [CW-1:0]     col, s1_col, s2_col, rd_col;
  logic              s1_vld, s2_vld, wr_en;
  logic [PIX_W-1:0]  s2_data, rd_pix;
  logic [9:0]        fetch_y;
  logic              in_rows, start_fetch, fetch_done, in_x, show, opaque;
  logic [ADDR_W-1:0] row_base;

  // Blink update is resolved before the line start so both see the new visibility
  always_comb begin
    blink_cnt_nx = blink_cnt;
    visible_nx   = visible;
    if (!i_blink_en) begin
      blink_cnt_nx = '0;
      visible_nx   = 1'b1;
    end else if (i_frame_start) begin
      if (blink_cnt == BW'(BLINK_FRAMES - 1)) begin
        blink_cnt_nx = '0;
        visible_nx   = ~visible;
      end else begin
        blink_cnt_nx = blink_cnt + 1'b1;
      end
    end
  end

  assign fetch_y     = (i_line_y == 10'(V_TOTAL - 1)) ? 10'd0 : i_line_y + 10'd1;
  assign in_rows     = (fetch_y >= 10'(POS_Y)) && (fetch_y < 10'(POS_Y + H));
  assign start_fetch = i_line_start && in_rows && visible_nx;
  assign row_base    = ADDR_W'(fetch_y - 10'(POS_Y)) * ADDR_W'(W);
  assign fetch_done  = (state == DRAIN) && s2_vld && (s2_col == LAST_COL);
  assign back        = ~front;
  assign wr_en       = s2_vld && !i_line_start;
  assign o_busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    if (i_line_start) begin
      state_nx = start_fetch ? FETCH : IDLE;
    end else begin
      case (state)
        FETCH:   if (col == LAST_COL) state_nx = DRAIN;
        DRAIN:   if (fetch_done) state_nx = IDLE;
        default: state_nx = state;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      blink_cnt   <= '0;
      visible     <= 1'b1;
      front       <= 1'b0;
      bank_valid  <= 2'b00;
      col         <= '0;
      o_rom_addr  <= '0;
      s1_vld      <= 1'b0;
      s1_col      <= '0;
      s2_vld      <= 1'b0;
      s2_col      <= '0;
      s2_data     <= '0;
      o_overrun   <= 1'b0;
      o_pix       <= '0;
      o_pix_valid <= 1'b0;
    end else begin
      blink_cnt <= blink_cnt_nx;
      visible   <= visible_nx;

      if (start_fetch) begin
        o_rom_addr <= row_base;
        col        <= '0;
      end else if (!i_line_start && state == FETCH && col != LAST_COL) begin
        o_rom_addr <= o_rom_addr + 1'b1;
        col        <= col + 1'b1;
      end

      // Column tag follows the ROM's one-cycle latency; a line start flushes it
      s1_vld  <= (state == FETCH) && !i_line_start;
      s1_col  <= col;
      s2_vld  <= s1_vld && !i_line_start;
      s2_col  <= s1_col;
      s2_data <= i_rom_data;

      if (i_line_start) begin
        front             <= ~front;
        bank_valid[front] <= 1'b0;
        if (!visible_nx) bank_valid <= 2'b00;
        if (state != IDLE) o_overrun <= 1'b1;
      end else if (fetch_done) begin
        bank_valid[back] <= 1'b1;
      end

      o_pix_valid <= show && opaque;
      o_pix       <= (show && opaque) ? rd_pix : '0;
    end
  end

  assign in_x   = (i_x >= 10'(POS_X)) && (i_x < 10'(POS_X + W));
  assign rd_col = in_x ? CW'(i_x - 10'(POS_X)) : '0;
  assign show   = bank_valid[front] && in_x && visible;
  assign opaque = (rd_pix != KEY);

  line_buffer_pp #(.DEPTH(W)) u_line_buf (
    .clk   (i_clk),
    .we    (wr_en),
    .wbank (back),
    .waddr (s2_col),
    .wdata (s2_data),
    .rbank (front),
    .raddr (rd_col),
    .rdata (rd_pix)
  );
endmodule
`default_nettype wire

// File: tb/tb_press_line_fetch.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_press_line_fetch: line-level reference model of banner prefetch
// Rev 1.0
// ------------------------------------------------------------------
module tb_press_line_fetch;
  localparam int W  = 168;
  localparam int PX = 236;
  localparam int PY = 400;
  localparam int HH = 12;
  localparam int VT = 525;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        line_start = 1'b0;
  logic        frame_start = 1'b0;
  logic        blink_en = 1'b0;
  logic [9:0]  line_y = '0;
  logic [9:0]  x = '0;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [7:0]  pix;
  logic        pix_valid, busy, overrun;
  logic [7:0]  rom [2048];

  int n_cmp = 0;
  int n_fail = 0;
  // model: row being fetched this line, row shown this line, frames since blink enabled
  int pend_row = -1;
  int prev_len = 1000;
  int disp_row = -1;
  int m_frames = 0;
  bit m_vis = 1'b1;
  bit m_ovr = 1'b0;
  int x_q[$];

  press_line_fetch #(.BLINK_FRAMES(BF)) dut (
    .i_clk(clk), .i_rst(rst), .i_line_start(line_start), .i_line_y(line_y),
    .i_frame_start(frame_start), .i_blink_en(blink_en), .i_x(x),
    .o_rom_addr(rom_addr), .i_rom_data(rom_data), .o_pix(pix),
    .o_pix_valid(pix_valid), .o_busy(busy), .o_overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [8:0] exp_pix(input int xv);
    logic [7:0] p;
    if (disp_row >= 0 && m_vis && xv >= PX && xv < PX + W) begin
      p = rom[disp_row * W + (xv - PX)];
      if (p != 8'h00) return {1'b1, p};
    end
    return 9'h000;
  endfunction

  task automatic model_reset();
    pend_row = -1; prev_len = 1000; disp_row = -1;
    m_frames = 0; m_vis = 1'b1; m_ovr = 1'b0;
  endtask

  // One video line: pulse at the current negedge, then len cycles of checks
  task automatic line(input int y, input int len, input bit fs);
    int fy, xprev;
    logic [8:0] e;
    if (pend_row >= 0 && prev_len <= W + 2) begin
      m_ovr = 1'b1;
      disp_row = -1;
    end else begin
      disp_row = pend_row;
    end
    if (!blink_en) m_frames = 0;
    else if (fs) m_frames++;
    m_vis = ((m_frames / BF) % 2) == 0;
    if (!m_vis) disp_row = -1;
    fy = (y == VT - 1) ? 0 : y + 1;
    pend_row = (m_vis && fy >= PY && fy < PY + HH) ? fy - PY : -1;
    prev_len = len;

    line_start = 1'b1; line_y = 10'(y); frame_start = fs; x = '0; xprev = 0;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      line_start = 1'b0; frame_start = 1'b0;
      n_cmp++;
      if (busy !== (pend_row >= 0 && k <= W + 2)) begin
        n_fail++;
        $display("FAIL busy y=%0d k=%0d: got %b want %b", y, k, busy, (pend_row >= 0 && k <= W + 2));
      end
      if (pend_row >= 0 && k <= W) begin
        n_cmp++;
        if (rom_addr !== 11'(pend_row * W + k - 1)) begin
          n_fail++;
          $display("FAIL rom_addr y=%0d k=%0d: got %0d want %0d", y, k, rom_addr, pend_row * W + k - 1);
        end
      end
      e = exp_pix(xprev);
      n_cmp++;
      if ({pix_valid, pix} !== e) begin
        n_fail++;
        $display("FAIL pix y=%0d x=%0d: got valid=%b pix=%h want valid=%b pix=%h",
                 y, xprev, pix_valid, pix, e[8], e[7:0]);
      end
      if (k < len) begin
        xprev = (x_q.size() > 0) ? x_q.pop_front() : int'($urandom_range(220, 420));
        x = 10'(xprev);
      end else begin
        x = '0;
      end
    end
    n_cmp++;
    if (overrun !== m_ovr) begin
      n_fail++;
      $display("FAIL overrun y=%0d: got %b want %b", y, overrun, m_ovr);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL %s busy: got %b want 0", tag, busy); end
    n_cmp++;
    if (rom_addr !== 11'd0) begin n_fail++; $display("FAIL %s rom_addr: got %0d want 0", tag, rom_addr); end
    n_cmp++;
    if (pix_valid !== 1'b0) begin n_fail++; $display("FAIL %s pix_valid: got %b want 0", tag, pix_valid); end
    n_cmp++;
    if (pix !== 8'h00) begin n_fail++; $display("FAIL %s pix: got %h want 00", tag, pix); end
    n_cmp++;
    if (overrun !== 1'b0) begin n_fail++; $display("FAIL %s overrun: got %b want 0", tag, overrun); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    x = 10'd241;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_first_fetch();
    blink_en = 1'b0;
    line(399, W + 10, 1'b0);
  endtask

  task automatic test_display();
    x_q = '{241, 235, 404, 236, 403, 241};
    line(400, W + 10, 1'b0);
  endtask

  task automatic test_last_row();
    line(410, W + 10, 1'b0);
    x_q = '{246, 240, 246};
    line(411, W + 10, 1'b0);
    line(524, W + 10, 1'b0);
    line(0, W + 10, 1'b0);
  endtask

  task automatic test_overrun();
    line(399, 50, 1'b0);
    x_q = '{241, 250, 300};
    line(400, W + 10, 1'b0);
    line(401, W + 10, 1'b0);
    line(402, W + 10, 1'b0);
  endtask

  task automatic test_blink();
    for (int f = 1; f <= 8; f++) begin
      blink_en = (f <= 6);
      x_q = '{241, 260, 300};
      line(524, W + 5, 1'b1);
      line(399, W + 5, 1'b0);
      x_q = '{241, 260, 300};
      line(400, W + 5, 1'b0);
      line(401, W + 5, 1'b0);
    end
    blink_en = 1'b0;
  endtask

  task automatic test_reset_mid_fetch();
    line(399, 80, 1'b0);
    rst = 1'b1;
    #1;
    check_zero_outputs("reset_mid_fetch");
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    line(399, W + 10, 1'b0);
    x_q = '{241, 300};
    line(400, W + 10, 1'b0);
  endtask

  task automatic test_random();
    int y, len;
    bit fs;
    for (int i = 0; i < 150; i++) begin
      y   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(523, 524)) : int'($urandom_range(396, 413));
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 172)) : int'($urandom_range(173, 200));
      fs  = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 15) == 0) blink_en = ~blink_en;
      line(y, len, fs);
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) begin
      rom[i] = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 7) == 0) rom[i] = 8'h00;
    end
    rom[5]    = 8'h3C;
    rom[1852] = 8'h5A;
    rom[1858] = 8'h00;

    test_reset();
    test_first_fetch();
    test_display();
    test_last_row();
    test_overrun();
    test_blink();
    test_reset_mid_fetch();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
